// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - request/response front-end for the serial divider
//
// Purpose: accepts division requests and latches the operands. It answers
// divide-by-zero and signed overflow directly. Every other request goes to
// div_serial with a one-cycle start pulse. The result is held on a
// valid/ready output until the consumer takes it.
//
// Optional feature macro: DIV_CTRL_SHORTCUT_EN
//   defined   -> divisor==1 and unsigned dividend<divisor are answered in IDLE
//   undefined -> those cases go through the divider (same result, longer latency)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             request handshake
//   in_sign, in_dividend,
//   in_divisor, in_id             request payload
//   out_valid/out_ready           result handshake
//   out_quotient, out_remainder,
//   out_id, out_dz                result payload (out_dz = divide-by-zero)
//   div_start                     one-cycle start pulse to the divider
//   div_done                      divider idle / result ready
//   div_sign, div_dividend,
//   div_divisor                   latched operands to the divider
//   div_quotient, div_remainder   divider results
module div_ctrl #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  input  logic [ID_W-1:0]   in_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quotient,
  output logic [DATA_W-1:0] out_remainder,
  output logic [ID_W-1:0]   out_id,
  output logic              out_dz,
  output logic              div_start,
  input  logic              div_done,
  output logic              div_sign,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              dz_q, dz_d;
  logic              wait_first_q, wait_first_d;

  logic              div_by_zero;
  logic              sgn_ovf;
  logic              short_hit;
  logic [DATA_W-1:0] short_q;
  logic [DATA_W-1:0] short_r;

  // Classification of the incoming request, evaluated on the live inputs so
  // the special cases can be answered in the accept cycle.
  always_comb begin
    div_by_zero = (in_divisor == '0);
    sgn_ovf     = in_sign && (in_dividend == MIN_NEG) && (in_divisor == '1);
    short_hit   = 1'b0;
    short_q     = '0;
    short_r     = '0;
`ifdef DIV_CTRL_SHORTCUT_EN
    if (in_divisor == ONE) begin
      short_hit = 1'b1;
      short_q   = in_dividend;
      short_r   = '0;
    end else if (!in_sign && (in_dividend < in_divisor)) begin
      short_hit = 1'b1;
      short_q   = '0;
      short_r   = in_dividend;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    id_d         = id_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    dz_d         = dz_q;
    wait_first_d = wait_first_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d     = in_sign;
          dividend_d = in_dividend;
          divisor_d  = in_divisor;
          id_d       = in_id;
          dz_d       = 1'b0;
          if (div_by_zero) begin
            quot_d  = '1;
            rem_d   = in_dividend;
            dz_d    = 1'b1;
            state_d = S_RESP;
          end else if (sgn_ovf) begin
            quot_d  = in_dividend;
            rem_d   = '0;
            state_d = S_RESP;
          end else if (short_hit) begin
            quot_d  = short_q;
            rem_d   = short_r;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      // Start is only issued to an idle divider; otherwise hold here.
      S_ISSUE: begin
        if (div_done) begin
          state_d      = S_WAIT;
          wait_first_d = 1'b1;
        end
      end
      // The divider may still report done in the cycle right after start,
      // so the first WAIT cycle never captures.
      S_WAIT: begin
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (div_done) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sign_q       <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      id_q         <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      dz_q         <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      id_q         <= id_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      dz_q         <= dz_d;
      wait_first_q <= wait_first_d;
    end
  end

  // ISSUE always leaves on the cycle start fires, so start cannot repeat.
  assign div_start     = (state_q == S_ISSUE) && div_done;
  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_RESP);
  assign out_quotient  = quot_q;
  assign out_remainder = rem_q;
  assign out_id        = id_q;
  assign out_dz        = dz_q;
  assign div_sign      = sign_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard testbench for div_ctrl
module tb_div_ctrl;

  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int DIV_BUSY = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic [DATA_W-1:0] in_dividend = '0;
  logic [DATA_W-1:0] in_divisor = '0;
  logic [ID_W-1:0]   in_id = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_quotient;
  logic [DATA_W-1:0] out_remainder;
  logic [ID_W-1:0]   out_id;
  logic              out_dz;
  logic              div_start;
  logic              div_done;
  logic              div_sign;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;

  always #5 clk = ~clk;

  div_ctrl #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_id(out_id), .out_dz(out_dz),
    .div_start(div_start), .div_done(div_done), .div_sign(div_sign),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Divider stand-in: sign-magnitude division, busy for DIV_BUSY cycles.
  logic              mdl_done;
  logic              force_busy = 1'b0;
  int                mdl_cnt;
  logic [DATA_W-1:0] mdl_q, mdl_r;
  assign div_done = mdl_done && !force_busy;

  always @(posedge clk) begin
    logic [DATA_W-1:0] ma, mb, uq, ur;
    if (rst) begin
      mdl_done      <= 1'b1;
      mdl_cnt       <= 0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_start && div_done) begin
      ma = (div_sign && div_dividend[DATA_W-1]) ? -div_dividend : div_dividend;
      mb = (div_sign && div_divisor[DATA_W-1])  ? -div_divisor  : div_divisor;
      uq = ma / mb;
      ur = ma % mb;
      mdl_q    <= (div_sign && (div_dividend[DATA_W-1] ^ div_divisor[DATA_W-1])) ? -uq : uq;
      mdl_r    <= (div_sign && div_dividend[DATA_W-1]) ? -ur : ur;
      mdl_done <= 1'b0;
      mdl_cnt  <= DIV_BUSY;
    end else if (!mdl_done) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_done      <= 1'b1;
        div_quotient  <= mdl_q;
        div_remainder <= mdl_r;
      end
    end
  end

  typedef struct {
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    logic [ID_W-1:0]   id;
    logic              dz;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t exp_calc(input logic sgn, input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b, input logic [ID_W-1:0] id);
    exp_t e;
    logic signed [DATA_W-1:0] sa, sbv;
    e.id = id;
    e.dz = 1'b0;
    sa   = a;
    sbv  = b;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = '0;
    end else if (sgn) begin
      e.q = sa / sbv; e.r = sa % sbv;
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  // Output monitor: handshake seen shortly after the falling edge.
  int unexpected = 0;
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) unexpected++;
      else begin
        e = sb.pop_front();
        check("quotient",  out_quotient,  e.q);
        check("remainder", out_remainder, e.r);
        check("id",        32'(out_id),   32'(e.id));
        check("dz",        32'(out_dz),   32'(e.dz));
      end
    end
  end

  int start_cnt = 0;
  int dbl_start = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (div_start && prev_start) dbl_start++;
    prev_start = div_start;
  end

  // Drive one request; returns at the falling edge of the cycle after accept.
  task automatic send(input logic sgn, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [ID_W-1:0] id);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_sign = sgn; in_dividend = a; in_divisor = b; in_id = id;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("accept_timeout", 32'(n), 32'(0));
    @(posedge clk);
    sb.push_back(exp_calc(sgn, a, b, id));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'(0));
    @(negedge clk);
  endtask

  int s0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_div_start", 32'(div_start), 32'(0));
    check("rst_quotient",  out_quotient, 32'(0));
    check("rst_remainder", out_remainder, 32'(0));
    check("rst_id_dz",     32'({out_id, out_dz}), 32'(0));
    check("rst_operands",  div_dividend | div_divisor | 32'(div_sign), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Unsigned 100/7 through the divider.
    s0 = start_cnt;
    send(1'b0, 32'd100, 32'd7, 4'd3);
    check("start_n1", 32'(div_start), 32'(1));
    wait_drain();
    check("start_once", 32'(start_cnt - s0), 32'(1));

    // Signed -7/2.
    send(1'b1, 32'hFFFF_FFF9, 32'd2, 4'd5);
    wait_drain();

    // Divide by zero: one-cycle answer, no divider start.
    s0 = start_cnt;
    send(1'b0, 32'd1234, 32'd0, 4'd6);
    check("dz_latency", 32'(out_valid), 32'(1));
    wait_drain();
    check("dz_no_start", 32'(start_cnt - s0), 32'(0));

    // Signed overflow.
    s0 = start_cnt;
    send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7);
    check("ovf_latency", 32'(out_valid), 32'(1));
    wait_drain();
    check("ovf_no_start", 32'(start_cnt - s0), 32'(0));

    // Same bit pattern unsigned is an ordinary division.
    send(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8);
    wait_drain();

    // Shortcut candidates: same result either way, latency depends on build.
    s0 = start_cnt;
    send(1'b0, 32'd5, 32'd9, 4'd9);
`ifdef DIV_CTRL_SHORTCUT_EN
    check("short_latency", 32'(out_valid), 32'(1));
`else
    check("short_via_div", 32'(div_start), 32'(1));
`endif
    wait_drain();
    send(1'b1, 32'hFFFF_FF85, 32'd1, 4'd10);
    wait_drain();
`ifdef DIV_CTRL_SHORTCUT_EN
    check("short_starts", 32'(start_cnt - s0), 32'(0));
`else
    check("short_starts", 32'(start_cnt - s0), 32'(2));
`endif

    // Busy divider: start must wait for div_done.
    force_busy = 1'b1;
    send(1'b0, 32'd1000, 32'd10, 4'd11);
    for (int i = 0; i < 3; i++) begin
      check("busy_no_start", 32'(div_start), 32'(0));
      check("busy_in_ready", 32'(in_ready), 32'(0));
      @(negedge clk);
    end
    force_busy = 1'b0;
    #1;
    check("busy_release_start", 32'(div_start), 32'(1));
    wait_drain();

    // Backpressure: result held stable while out_ready is low.
    out_ready = 1'b0;
    send(1'b0, 32'd50, 32'd3, 4'd12);
    s0 = 0;
    while (!out_valid && s0 < 500) begin
      @(negedge clk);
      s0++;
    end
    check("bp_valid_timeout", 32'(out_valid), 32'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid",    32'(out_valid), 32'(1));
      check("bp_quotient", out_quotient, 32'd16);
      check("bp_remainder", out_remainder, 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'(1));
    check("bp_release_valid", 32'(out_valid), 32'(0));
    wait_drain();

    // Reset while waiting on the divider drops the in-flight result.
    send(1'b0, 32'd200, 32'd3, 4'd13);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("wait_rst_valid", 32'(out_valid), 32'(0));
    check("wait_rst_in_ready", 32'(in_ready), 32'(1));

    send(1'b1, 32'd9, 32'hFFFF_FFFC, 4'd14);
    wait_drain();

    check("unexpected_out", 32'(unexpected), 32'(0));
    check("double_start", 32'(dbl_start), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Request/response front-end for the serial divider (`div_serial`). It accepts division requests on a valid/ready handshake, latches the operands, and resolves the special cases itself: divide-by-zero and signed overflow. All other requests are issued to the divider with a one-cycle start pulse. When the divider's done returns, the result is held on a valid/ready output port until the consumer takes it.

## Interface
- DATA_W, 32, operand/result width
- ID_W, 4, request tag width, returned unchanged with the result
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- in_sign  in  1  1 = signed division, 0 = unsigned
- in_dividend  in  DATA_W  dividend
- in_divisor  in  DATA_W  divisor
- in_id  in  ID_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_quotient  out  DATA_W  quotient
- out_remainder  out  DATA_W  remainder
- out_id  out  ID_W  tag of the request
- out_dz  out  1  result came from a divide-by-zero
- div_start  out  1  one-cycle start pulse to the divider
- div_done  in  1  divider idle / result ready
- div_sign, div_dividend, div_divisor  out  1/DATA_W/DATA_W  latched operands to the divider
- div_quotient, div_remainder  in  DATA_W  divider results

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid, latch sign, operands and id, then classify the request:
  - Divisor==0 -> RESP with quotient=all ones, remainder=dividend, dz=1.
  - Signed, dividend=2^(DATA_W-1) and divisor=all ones -> RESP with quotient=dividend, remainder=0, dz=0.
  - Shortcut hit (see Configuration) -> RESP with the shortcut result.
  - Otherwise -> ISSUE.
- ISSUE: assert div_start for exactly one cycle, and only when div_done=1; if div_done=0, hold in ISSUE with div_start=0. Then go to WAIT.
- WAIT: div_done is ignored in the first WAIT cycle. After that, the first cycle with div_done=1 captures div_quotient and div_remainder into the output registers and moves to RESP.
- RESP: out_valid=1 and the outputs stay stable. When out_ready=1, go to IDLE. A new request can be accepted no earlier than the cycle after the result is taken; there is no overlap.
- div_sign, div_dividend and div_divisor are driven from the latched registers and stay stable from ISSUE through WAIT.
- in_ready is a combinational decode of state==IDLE.
- rst mid-operation: return to IDLE and drop any in-flight result. The divider is not reset by this block; it shares rst.

## Timing
- Reset values: out_valid=0, div_start=0, out_quotient=0, out_remainder=0, out_id=0, out_dz=0, latched operands=0. in_ready=1 in the cycle after rst deasserts.
- Special case: request accepted at edge N -> out_valid=1 from edge N+1.
- Normal case (divider idle): accept at edge N; div_start high in cycle N+1; result in RESP after div_done returns, which totals DATA_W+4 cycles for div_serial.
- out_valid stays high until the cycle after out_ready is sampled high. The output must not change while out_valid=1 and out_ready=0.
- div_start is never high for two consecutive cycles.

## Configuration
- DIV_CTRL_SHORTCUT_EN.
- Defined: two extra fast-path cases, handled in IDLE with no divider start (1-cycle result like the special cases):
  - Divisor==1 -> quotient=dividend, remainder=0.
  - Unsigned request with dividend<divisor -> quotient=0, remainder=dividend.
- Undefined: these cases go through the divider. Results are identical; only latency differs.

## Test plan
- Unsigned 100/7 with out_ready=1 -> one div_start pulse; out_quotient=14, out_remainder=2, out_dz=0; out_id matches in_id.
- Signed -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- 1234/0 -> out_valid one cycle after accept, quotient 0xFFFFFFFF, remainder 1234, out_dz=1, div_start never asserted.
- Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, no div_start.
- Backpressure: out_ready=0 for 10 cycles after result -> outputs stable, in_ready=0; release -> in_ready=1 next cycle.
- With DIV_CTRL_SHORTCUT_EN, 5/9 unsigned -> quotient 0, remainder 5 in 1 cycle. Repeat without the macro -> same result via the divider. Finally, rst during WAIT -> out_valid=0 and in_ready=1 after reset.
